// File: rtl/wakeup_delay_pipeline_if.sv
`default_nettype none
// ============================================================================
//  Module      : wakeup_delay_pipeline_if
//  Description : Bundle between the issue stage and the wakeup delay pipeline.
//                The issue side (master) drives stall, issue, issuePtr,
//                issueLatency, flush and flushVector. It receives
//                latencyFree, wakeup, wakeupDstVector, collision and pending.
//                The delay pipeline is the slave side.
//  Revision    : 1.0  initial release
// ============================================================================
interface wakeup_delay_pipeline_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int ENTRY_NUM   = 16,
    parameter int MAX_LAT     = 3,
    parameter int PTR_W       = $clog2(ENTRY_NUM),
    parameter int LAT_W       = $clog2(MAX_LAT + 1)
);
    logic                                    stall;
    logic [ISSUE_WIDTH-1:0]                  issue;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0]       issuePtr;
    logic [ISSUE_WIDTH-1:0][LAT_W-1:0]       issueLatency;
    logic                                    flush;
    logic [ENTRY_NUM-1:0]                    flushVector;
    logic [ISSUE_WIDTH-1:0][MAX_LAT-1:0]     latencyFree;
    logic [ISSUE_WIDTH-1:0]                  wakeup;
    logic [ISSUE_WIDTH-1:0][ENTRY_NUM-1:0]   wakeupDstVector;
    logic                                    collision;
    logic                                    pending;

    modport master (
        output stall, issue, issuePtr, issueLatency, flush, flushVector,
        input  latencyFree, wakeup, wakeupDstVector, collision, pending
    );

    modport slave (
        input  stall, issue, issuePtr, issueLatency, flush, flushVector,
        output latencyFree, wakeup, wakeupDstVector, collision, pending
    );
endinterface
`default_nettype wire

// File: rtl/wakeup_delay_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : wakeup_delay_pipeline
//  Description : Producer side of the scheduler wakeup path. Each issued
//                producer is held in a per-lane delay line for its execution
//                latency. It then appears on wakeup/wakeupDstVector, so the
//                dependency matrix clears the column when the result becomes
//                bypassable. Supports stall hold and selective squash.
//  Ports       : clk   - clock
//                rst   - synchronous reset, active low (0 = reset)
//                bus   - wakeup_delay_pipeline_if.slave:
//                        in : stall, issue, issuePtr, issueLatency,
//                             flush, flushVector
//                        out: latencyFree, wakeup, wakeupDstVector,
//                             collision (sticky), pending
//  Revision    : 1.0  initial release
// ============================================================================
module wakeup_delay_pipeline #(
    parameter int ISSUE_WIDTH = 2,
    parameter int ENTRY_NUM   = 16,
    parameter int MAX_LAT     = 3,
    parameter int PTR_W       = $clog2(ENTRY_NUM),
    parameter int LAT_W       = $clog2(MAX_LAT + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    wakeup_delay_pipeline_if.slave    bus
);

    logic [ENTRY_NUM-1:0]   w_flushMask;
    logic [ISSUE_WIDTH-1:0] w_collLane;
    logic [ISSUE_WIDTH-1:0] w_pendLane;
    logic                   r_collision;

    assign w_flushMask = bus.flush ? bus.flushVector : '0;

    for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_lane
        // r_slot[k] holds the entries whose wakeup is due k cycles from now.
        logic [MAX_LAT-1:0][ENTRY_NUM-1:0] r_slot;
        // w_ext has an always-empty slot appended above the top slot.
        // The shift and latencyFree logic then reads slot k+1 uniformly.
        logic [MAX_LAT:0][ENTRY_NUM-1:0]   w_ext;
        logic [MAX_LAT-1:0][ENTRY_NUM-1:0] w_shift;
        logic [MAX_LAT-1:0][ENTRY_NUM-1:0] w_new;
        logic [MAX_LAT-1:0][ENTRY_NUM-1:0] w_next;
        logic [MAX_LAT-1:0]                w_free;
        logic [PTR_W-1:0]                  w_ptr;
        logic [ENTRY_NUM-1:0]              w_ins;
        logic                              w_coll;

        assign w_ptr = bus.issuePtr[l];
        assign w_ext = {{ENTRY_NUM{1'b0}}, r_slot};

        // Masking the insert with the flush vector means an entry flushed
        // in its own issue cycle is never woken.
        assign w_ins = bus.issue[l] ? ((ENTRY_NUM'(1) << w_ptr) & ~w_flushMask) : '0;

        // Latency 0 or above MAX_LAT matches no slot, so it acts as no issue.
        always_comb begin
            w_shift = '0;
            w_new   = '0;
            w_next  = '0;
            w_free  = '0;
            w_coll  = 1'b0;
            for (int k = 0; k < MAX_LAT; k++) begin
                w_free[k]  = (w_ext[k+1] == '0);
                w_shift[k] = w_ext[k+1] & ~w_flushMask;
                if (bus.issueLatency[l] == LAT_W'(k + 1)) begin
                    w_new[k] = w_ins;
                end
                w_next[k] = w_shift[k] | w_new[k];
                if ((w_new[k] != '0) && (w_shift[k] != '0)) begin
                    w_coll = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_slot <= '0;
            end else if (!bus.stall) begin
                r_slot <= w_next;
            end
        end

        assign bus.wakeup[l]          = |r_slot[0];
        assign bus.wakeupDstVector[l] = r_slot[0];
        assign bus.latencyFree[l]     = w_free;
        assign w_collLane[l]          = w_coll;
        assign w_pendLane[l]          = |r_slot;
    end

    // Collision stays set once it is seen; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_collision <= 1'b0;
        end else if (!bus.stall && (|w_collLane)) begin
            r_collision <= 1'b1;
        end
    end

    assign bus.collision = r_collision;
    assign bus.pending   = |w_pendLane;

endmodule
`default_nettype wire

// File: tb/tb_wakeup_delay_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wakeup_delay_pipeline
//  Description : Bench for wakeup_delay_pipeline. The reference model is an
//                event list: each pending wakeup is {lane, entry, cycles
//                remaining}. Directed scenarios pin exact values, and a
//                per-cycle compare process checks every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wakeup_delay_pipeline;
    localparam int IW = 2;
    localparam int EN = 16;
    localparam int ML = 3;

    logic clk;
    logic rst;

    wakeup_delay_pipeline_if #(.ISSUE_WIDTH(IW), .ENTRY_NUM(EN), .MAX_LAT(ML)) bus ();

    wakeup_delay_pipeline #(.ISSUE_WIDTH(IW), .ENTRY_NUM(EN), .MAX_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int ptr;
        int rem;   // 0 = being delivered in the current cycle
    } ev_t;

    ev_t  evq[$];
    logic mColl;
    bit   chkOn;
    int   nVec;
    int   nErr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic expWake(input int l);
        foreach (evq[i]) if (evq[i].lane == l && evq[i].rem == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [EN-1:0] expVec(input int l);
        logic [EN-1:0] v = '0;
        foreach (evq[i]) if (evq[i].lane == l && evq[i].rem == 0) v[evq[i].ptr] = 1'b1;
        return v;
    endfunction

    function automatic logic expFree(input int l, input int k);
        foreach (evq[i]) if (evq[i].lane == l && evq[i].rem == k + 1) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the event list across one clock edge from the current inputs.
    task automatic modelStep();
        ev_t nq[$];
        logic [EN-1:0] f;
        if (!rst) begin
            evq.delete();
            mColl = 1'b0;
        end else if (!bus.stall) begin
            f = bus.flush ? bus.flushVector : '0;
            foreach (evq[i]) begin
                if (evq[i].rem != 0 && !f[evq[i].ptr]) begin
                    ev_t e = evq[i];
                    e.rem--;
                    nq.push_back(e);
                end
            end
            for (int l = 0; l < IW; l++) begin
                int lat = int'(bus.issueLatency[l]);
                int p   = int'(bus.issuePtr[l]);
                if (bus.issue[l] && lat >= 1 && lat <= ML && !f[p]) begin
                    ev_t e;
                    foreach (nq[i]) if (nq[i].lane == l && nq[i].rem == lat - 1) mColl = 1'b1;
                    e.lane = l; e.ptr = p; e.rem = lat - 1;
                    nq.push_back(e);
                end
            end
            evq = nq;
        end
    endtask

    always @(posedge clk) begin
        if (rst && !bus.stall) begin
            for (int l = 0; l < IW; l++) begin
                if (bus.issue[l]) begin
                    assert (bus.issueLatency[l] >= 1 && bus.issueLatency[l] <= ML)
                        else $error("illegal issueLatency on lane %0d", l);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chkOn) begin
            for (int l = 0; l < IW; l++) begin
                chk($sformatf("cyc wakeup[%0d]", l), 64'(bus.wakeup[l]), 64'(expWake(l)));
                chk($sformatf("cyc vector[%0d]", l), 64'(bus.wakeupDstVector[l]), 64'(expVec(l)));
                for (int k = 0; k < ML; k++)
                    chk($sformatf("cyc latencyFree[%0d][%0d]", l, k),
                        64'(bus.latencyFree[l][k]), 64'(expFree(l, k)));
            end
            chk("cyc pending", 64'(bus.pending), 64'(evq.size() != 0));
            chk("cyc collision", 64'(bus.collision), 64'(mColl));
        end
    end

    task automatic cyc();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall        = 1'b0;
        bus.issue        = '0;
        bus.issuePtr     = '0;
        bus.issueLatency = '{default: 2'd1};
        bus.flush        = 1'b0;
        bus.flushVector  = '0;
    endtask

    task automatic iss(input int l, input int p, input int lat);
        bus.issue[l]        = 1'b1;
        bus.issuePtr[l]     = 4'(p);
        bus.issueLatency[l] = 2'(lat);
    endtask

    task automatic doReset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        nVec  = 0;
        nErr  = 0;
        chkOn = 1'b0;
        mColl = 1'b0;
        rst   = 1'b0;
        idle();
        cyc();
        cyc();
        chkOn = 1'b1;
        chk("reset wakeup", 64'(bus.wakeup), 64'h0);
        chk("reset pending", 64'(bus.pending), 64'h0);
        chk("reset latencyFree", 64'(bus.latencyFree), 64'h3f);
        rst = 1'b1;

        // 1: lane0 ptr5 L1
        iss(0, 5, 1); cyc(); idle();
        chk("t1 wakeup0", 64'(bus.wakeup[0]), 64'h1);
        chk("t1 vector0", 64'(bus.wakeupDstVector[0]), 64'h0020);
        cyc();
        chk("t1 wakeup0 after", 64'(bus.wakeup[0]), 64'h0);

        // 2: lane1 ptr3 L3 with two stalled cycles
        iss(1, 3, 3); cyc(); idle();
        chk("t2 early t1", 64'(bus.wakeup[1]), 64'h0);
        bus.stall = 1'b1; iss(1, 6, 1); cyc();
        chk("t2 early t2", 64'(bus.wakeup[1]), 64'h0);
        cyc(); idle();
        chk("t2 early t3", 64'(bus.wakeup[1]), 64'h0);
        cyc();
        chk("t2 early t4", 64'(bus.wakeup[1]), 64'h0);
        cyc();
        chk("t2 wakeup1 t5", 64'(bus.wakeup[1]), 64'h1);
        chk("t2 vector1 t5", 64'(bus.wakeupDstVector[1]), 64'h0008);
        cyc();
        chk("t2 wakeup1 t6", 64'(bus.wakeup[1]), 64'h0);

        // 3: lane0 ptr7 L2 flushed one cycle later
        iss(0, 7, 2); cyc(); idle();
        chk("t3 pending t1", 64'(bus.pending), 64'h1);
        bus.flush = 1'b1; bus.flushVector = 16'h0080; cyc(); idle();
        chk("t3 wakeup0 t2", 64'(bus.wakeup[0]), 64'h0);
        chk("t3 pending t2", 64'(bus.pending), 64'h0);

        // flush does not hide a wakeup already in its delivery cycle
        iss(0, 6, 1); cyc(); idle();
        bus.flush = 1'b1; bus.flushVector = 16'h0040;
        chk("flush current wakeup", 64'(bus.wakeup[0]), 64'h1);
        cyc(); idle();

        // 4: collision ptr2 L3 then ptr9 L1
        chk("t4 no collision yet", 64'(bus.collision), 64'h0);
        iss(0, 2, 3); cyc(); idle();
        cyc();
        chk("t4 latencyFree00 t2", 64'(bus.latencyFree[0][0]), 64'h0);
        chk("t4 latencyFree02 t2", 64'(bus.latencyFree[0][2]), 64'h1);
        iss(0, 9, 1); cyc(); idle();
        chk("t4 vector0 t3", 64'(bus.wakeupDstVector[0]), 64'h0204);
        chk("t4 collision t3", 64'(bus.collision), 64'h1);
        cyc();

        // 5: issue and flush of the same entry together
        iss(0, 4, 2); bus.flush = 1'b1; bus.flushVector = 16'h0010; cyc(); idle();
        chk("t5 pending t1", 64'(bus.pending), 64'h0);
        cyc();
        chk("t5 wakeup0 t2", 64'(bus.wakeup[0]), 64'h0);
        chk("t5 collision sticky", 64'(bus.collision), 64'h1);

        // both lanes carrying the same entry
        iss(0, 11, 2); iss(1, 11, 2); cyc(); idle(); cyc();
        chk("dual vector0", 64'(bus.wakeupDstVector[0]), 64'h0800);
        chk("dual vector1", 64'(bus.wakeupDstVector[1]), 64'h0800);

        // 6: reset while a wakeup is in flight
        iss(0, 1, 3); cyc(); idle();
        doReset();
        chk("t6 wakeup", 64'(bus.wakeup), 64'h0);
        chk("t6 vectors", 64'(bus.wakeupDstVector), 64'h0);
        chk("t6 pending", 64'(bus.pending), 64'h0);
        chk("t6 collision", 64'(bus.collision), 64'h0);
        chk("t6 latencyFree", 64'(bus.latencyFree), 64'h3f);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6 no post-reset wakeup", 64'(bus.wakeup), 64'h0);
        end

        // mixed traffic, checked every cycle against the model
        for (int i = 0; i < 200; i++) begin
            idle();
            for (int l = 0; l < IW; l++)
                if ($urandom_range(0, 1) == 1) iss(l, int'($urandom_range(0, EN - 1)), int'($urandom_range(1, ML)));
            bus.stall = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.flush       = 1'b1;
                bus.flushVector = 16'($urandom);
            end
            cyc();
        end
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
`default_nettype wire
